// File: rtl/step_run_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : step_run_pkg
//  Description : Shared types and default constants for the step/run
//                front-panel controller.
//  Revision    : 1.0 - initial release
// ============================================================================

package step_run_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } ctrl_state_t;

    localparam int DEFAULT_SYNC_STAGES = 2;

endpackage : step_run_pkg

`default_nettype wire

// File: rtl/step_run_controller_btn_pulse.sv
`default_nettype none
// ============================================================================
//  Module      : btn_pulse
//  Description : Synchronises one raw push-button and emits a registered
//                single-cycle pulse on each sampled rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================

module btn_pulse
    import step_run_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic Clk,
    input  logic Reset,
    input  logic BtnRaw,
    output logic Pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   level_q;
    logic                   level_d;
    logic                   pulse_q;
    logic                   pulse_d;

    // The last synchroniser stage is the only one safe to consume.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], BtnRaw};
        level_d = sync_q[SYNC_STAGES-1];
        pulse_d = sync_q[SYNC_STAGES-1] & ~level_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign Pulse = pulse_q;

endmodule : btn_pulse

`default_nettype wire

// File: rtl/step_run_controller.sv
`default_nettype none
// ============================================================================
//  Module      : step_run_controller
//  Description : Front-panel execution controller: turns Step/Run/Halt
//                buttons into the core's clock-enable and counts issued steps.
//  Revision    : 1.0 - initial release
// ============================================================================

module step_run_controller
    import step_run_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int RATE_DIV    = 4,
    parameter int CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             StepBtn,
    input  logic             RunBtn,
    input  logic             HaltBtn,
    input  logic             CpuDone,
    output logic             CpuEn,
    output logic             Running,
    output logic             Halted,
    output logic [CNT_W-1:0] StepCount
);

    localparam int             RATE_W   = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
    localparam logic [RATE_W-1:0] RATE_MAX = RATE_W'(RATE_DIV - 1);

    logic step_pulse;
    logic run_pulse;
    logic halt_pulse;

    ctrl_state_t       state_q;
    ctrl_state_t       state_d;
    logic [RATE_W-1:0] rate_cnt_q;
    logic [RATE_W-1:0] rate_cnt_d;
    logic [CNT_W-1:0]  step_count_q;
    logic [CNT_W-1:0]  step_count_d;

    logic cpu_en;
    logic running;
    logic halted;

    btn_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_step_btn (
        .Clk    (Clk),
        .Reset  (Reset),
        .BtnRaw (StepBtn),
        .Pulse  (step_pulse)
    );

    btn_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_run_btn (
        .Clk    (Clk),
        .Reset  (Reset),
        .BtnRaw (RunBtn),
        .Pulse  (run_pulse)
    );

    btn_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_halt_btn (
        .Clk    (Clk),
        .Reset  (Reset),
        .BtnRaw (HaltBtn),
        .Pulse  (halt_pulse)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            rate_cnt_q   <= '0;
            step_count_q <= '0;
        end else begin
            state_q      <= state_d;
            rate_cnt_q   <= rate_cnt_d;
            step_count_q <= step_count_d;
        end
    end

    // A pending done or halt in IDLE outranks Run/Step and simply swallows them.
    always_comb begin
        state_d    = state_q;
        rate_cnt_d = rate_cnt_q;
        case (state_q)
            IDLE: begin
                if (CpuDone || halt_pulse) begin
                    state_d = IDLE;
                end else if (run_pulse) begin
                    state_d    = RUN;
                    rate_cnt_d = '0;
                end else if (step_pulse) begin
                    state_d = STEP;
                end
            end
            STEP: begin
                state_d = CpuDone ? DONE : IDLE;
            end
            RUN: begin
                if (CpuDone) begin
                    state_d    = DONE;
                    rate_cnt_d = '0;
                end else if (halt_pulse) begin
                    state_d    = IDLE;
                    rate_cnt_d = '0;
                end else if (rate_cnt_q == RATE_MAX) begin
                    rate_cnt_d = '0;
                end else begin
                    rate_cnt_d = rate_cnt_q + RATE_W'(1);
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d    = IDLE;
                rate_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        cpu_en  = 1'b0;
        running = 1'b0;
        halted  = 1'b0;
        case (state_q)
            STEP: cpu_en = 1'b1;
            RUN: begin
                running = 1'b1;
                cpu_en  = (rate_cnt_q == RATE_MAX);
            end
            DONE: halted = 1'b1;
            default: begin
                cpu_en  = 1'b0;
                running = 1'b0;
                halted  = 1'b0;
            end
        endcase
    end

    always_comb begin
        step_count_d = step_count_q;
        if (cpu_en) begin
            step_count_d = step_count_q + CNT_W'(1);
        end
    end

    assign CpuEn     = cpu_en;
    assign Running   = running;
    assign Halted    = halted;
    assign StepCount = step_count_q;

endmodule : step_run_controller

`default_nettype wire
